// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch stage: default widths, reset PC, bubble encoding
// and the redirect-hold FSM state type.
package fetch_pc_ctrl_pkg;

  localparam int          WIDTH_DEFAULT    = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_DEFAULT      = 32'h0000_0000;
  localparam int          PC_STEP          = 4;

  typedef enum logic {
    RUN        = 1'b0,
    HOLD_REDIR = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_ctrl_ifid_reg.sv
// IF/ID pipeline register: holds on stall, inserts a bubble on redirect,
// otherwise captures the fetched instruction and its PC+4.
module ifid_reg
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int               WIDTH = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] NOP   = NOP_DEFAULT[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             bubble,
  input  logic [WIDTH-1:0] pc4_in,
  input  logic [WIDTH-1:0] instr_in,
  output logic [WIDTH-1:0] pc4_out,
  output logic [WIDTH-1:0] instr_out,
  output logic             valid_out
);

  logic [WIDTH-1:0] pc4_q,   pc4_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;

  // Hold beats bubble so a stalled stage never loses the instruction it owns.
  always_comb begin
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (!hold) begin
      if (bubble) begin
        pc4_d   = '0;
        instr_d = NOP;
        valid_d = 1'b0;
      end else begin
        pc4_d   = pc4_in;
        instr_d = instr_in;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc4_q   <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc4_out   = pc4_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: owns the PC register, next-PC selection and a small
// FSM that parks a redirect arriving during a stall until the stall releases.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT[WIDTH-1:0],
  parameter logic [WIDTH-1:0] NOP      = NOP_DEFAULT[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] imem_instr,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] ifid_pc4,
  output logic [WIDTH-1:0] ifid_instr,
  output logic             ifid_valid,
  output logic             redirect_pending
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  logic             redirect;
  logic [WIDTH-1:0] live_target;
  logic [WIDTH-1:0] pc_plus4;
  logic             ifid_hold;
  logic             ifid_bubble;

  // Jump has priority over a simultaneous taken branch; targets are word-aligned.
  always_comb begin
    redirect    = jump | branch_taken;
    live_target = (jump ? jump_target : branch_target) & ALIGN_MASK;
    pc_plus4    = pc_q + WIDTH'(PC_STEP);
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    ifid_hold     = 1'b1;
    ifid_bubble   = 1'b0;
    case (state_q)
      RUN: begin
        if (!stall) begin
          ifid_hold = 1'b0;
          if (redirect) begin
            pc_d        = live_target;
            ifid_bubble = 1'b1;
          end else begin
            pc_d = pc_plus4;
          end
        end else if (redirect) begin
          pend_target_d = live_target;
          state_d       = HOLD_REDIR;
        end
      end
      HOLD_REDIR: begin
        if (redirect) begin
          pend_target_d = live_target;
        end
        if (!stall) begin
          ifid_hold   = 1'b0;
          ifid_bubble = 1'b1;
          pc_d        = redirect ? live_target : pend_target_q;
          state_d     = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
    end
  end

  ifid_reg #(
    .WIDTH (WIDTH),
    .NOP   (NOP)
  ) u_ifid_reg (
    .clk       (clk),
    .reset     (reset),
    .hold      (ifid_hold),
    .bubble    (ifid_bubble),
    .pc4_in    (pc_plus4),
    .instr_in  (imem_instr),
    .pc4_out   (ifid_pc4),
    .instr_out (ifid_instr),
    .valid_out (ifid_valid)
  );

  assign pc_out           = pc_q;
  assign redirect_pending = (state_q == HOLD_REDIR);

endmodule
